game_board_mover: RTL and testbench

//   Applies one 2048 move (left/right/up/down) to a full NxN board. Processes
//   one row or column per clock using a single shared line push/merge datapath.

---
 rtl/game_board_mover.sv | 154 +++++++++++++++
 tb/tb_game_board_mover.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/game_board_mover.sv
// Applies one 2048 move to an NxN board, one row/column per cycle through a shared push/merge line.
// Latency: done pulses N+1 cycles after start is accepted, and results are held until the next start.
// Backpressure: start is only sampled in IDLE; requests arriving in RUN or DONE are dropped.
module game_board_mover #(
    parameter int N       = 4,
    parameter int CELL_W  = 4,
    parameter int SCORE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            direction,
    input  logic [N*N*CELL_W-1:0] board_in,
    output logic                  busy,
    output logic                  done,
    output logic [N*N*CELL_W-1:0] board_out,
    output logic                  changed,
    output logic [SCORE_W-1:0]    score_add
);
    localparam int BW = N * N * CELL_W;
    localparam int KW = $clog2(N);
    localparam logic [CELL_W-1:0]  MAX_V = '1;
    localparam logic [SCORE_W-1:0] MAX_S = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, next_state;
    logic [BW-1:0]       work, orig, work_next;
    logic [1:0]          dir_q;
    logic [KW-1:0]       line_k;
    logic [SCORE_W-1:0]  acc, acc_next;
    logic [CELL_W-1:0]   line_in  [N];
    logic [CELL_W-1:0]   line_out [N];
    logic                last_line;

    assign last_line = (line_k == KW'(N - 1));

    // Cell index of element i of line k; element 0 sits on the edge tiles move toward.
    function automatic int cell_idx(input logic [1:0] d, input int k, input int i);
        case (d)
            2'd0:    return k * N + i;
            2'd1:    return k * N + (N - 1 - i);
            2'd2:    return i * N + k;
            default: return (N - 1 - i) * N + k;
        endcase
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CELL_W-1:0]  e);
        logic [SCORE_W:0] sum;
        if (int'(e) >= SCORE_W) return MAX_S;
        sum = {1'b0, a} + ((SCORE_W + 1)'(1) << e);
        return sum[SCORE_W] ? MAX_S : sum[SCORE_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++)
            line_in[i] = work[cell_idx(dir_q, int'(line_k), i) * CELL_W +: CELL_W];
    end

    // Single pass: hold one pending tile; an equal non-max successor merges with it and
    // clears the pending slot, so a freshly merged tile can never merge again.
    always_comb begin
        int                pos;
        logic              pend;
        logic [CELL_W-1:0] pv;
        pos      = 0;
        pend     = 1'b0;
        pv       = '0;
        acc_next = acc;
        for (int i = 0; i < N; i++) line_out[i] = '0;
        for (int i = 0; i < N; i++) begin
            if (line_in[i] != '0) begin
                if (pend && (pv == line_in[i]) && (pv != MAX_V)) begin
                    line_out[pos] = pv + 1'b1;
                    acc_next      = sat_add(acc_next, pv + 1'b1);
                    pos           = pos + 1;
                    pend          = 1'b0;
                end else begin
                    if (pend) begin
                        line_out[pos] = pv;
                        pos           = pos + 1;
                    end
                    pv   = line_in[i];
                    pend = 1'b1;
                end
            end
        end
        if (pend) line_out[pos] = pv;
    end

    always_comb begin
        work_next = work;
        for (int i = 0; i < N; i++)
            work_next[cell_idx(dir_q, int'(line_k), i) * CELL_W +: CELL_W] = line_out[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_line) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            orig      <= '0;
            dir_q     <= '0;
            line_k    <= '0;
            acc       <= '0;
            board_out <= '0;
            changed   <= 1'b0;
            score_add <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work   <= board_in;
                        orig   <= board_in;
                        dir_q  <= direction;
                        line_k <= '0;
                        acc    <= '0;
                    end
                end
                RUN: begin
                    work   <= work_next;
                    acc    <= acc_next;
                    line_k <= line_k + 1'b1;
                    // Results are published on the same edge that finishes the last line.
                    if (last_line) begin
                        board_out <= work_next;
                        changed   <= (work_next != orig);
                        score_add <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_game_board_mover.sv
// Scoreboard bench for game_board_mover: three builds (4x4/16-bit score, 4x4/4-bit score, 3x3).
// Hex boards: the rightmost hex digit is cell(0,0); each row takes N digits.
module tb_game_board_mover;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b, start_c;
    logic [1:0]  direction;
    logic [63:0] board_in;

    logic        busy_a, done_a, chg_a;
    logic [63:0] bo_a;
    logic [15:0] sc_a;
    logic        busy_b, done_b, chg_b;
    logic [63:0] bo_b;
    logic [3:0]  sc_b;
    logic        busy_c, done_c, chg_c;
    logic [35:0] bo_c;
    logic [15:0] sc_c;

    typedef struct {
        logic [63:0] board;
        logic        chg;
        logic [15:0] score;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    game_board_mover #(.N(4), .CELL_W(4), .SCORE_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .direction(direction), .board_in(board_in),
        .busy(busy_a), .done(done_a), .board_out(bo_a), .changed(chg_a), .score_add(sc_a));

    game_board_mover #(.N(4), .CELL_W(4), .SCORE_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .direction(direction), .board_in(board_in),
        .busy(busy_b), .done(done_b), .board_out(bo_b), .changed(chg_b), .score_add(sc_b));

    game_board_mover #(.N(3), .CELL_W(4), .SCORE_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .direction(direction), .board_in(board_in[35:0]),
        .busy(busy_c), .done(done_c), .board_out(bo_c), .changed(chg_c), .score_add(sc_c));

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_check++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_done(input string tag, input exp_t e, input logic [63:0] bo,
                              input logic chg, input logic [15:0] sc, input logic bsy);
        check({tag, "_board"},   bo,  e.board);
        check({tag, "_changed"}, 64'(chg), 64'(e.chg));
        check({tag, "_score"},   64'(sc),  64'(e.score));
        check({tag, "_done_cyc"}, 64'(cyc), 64'(e.cyc));
        check({tag, "_busy_in_done"}, 64'(bsy), 64'd0);
    endtask

    task automatic spurious(input string tag);
        n_check++;
        n_fail++;
        $display("FAIL %s_spurious_done: got done=1, required no done", tag);
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            exp_t e;
            if (q_a.size() == 0) spurious("a");
            else begin
                e = q_a.pop_front();
                check_done("a", e, bo_a, chg_a, sc_a, busy_a);
            end
        end
        if (done_b) begin
            exp_t e;
            if (q_b.size() == 0) spurious("b");
            else begin
                e = q_b.pop_front();
                check_done("b", e, bo_b, chg_b, {12'd0, sc_b}, busy_b);
            end
        end
        if (done_c) begin
            exp_t e;
            if (q_c.size() == 0) spurious("c");
            else begin
                e = q_c.pop_front();
                check_done("c", e, {28'd0, bo_c}, chg_c, sc_c, busy_c);
            end
        end
    end

    // Issues one move on instance inst (0=a, 1=b, 2=c) and queues its expected result.
    task automatic do_move(input int inst, input logic [1:0] d, input logic [63:0] b,
                           input logic [63:0] eb, input logic ec, input logic [15:0] es);
        exp_t e;
        int   nn;
        nn = (inst == 2) ? 3 : 4;
        @(negedge clk);
        direction = d;
        board_in  = b;
        e.board = eb;
        e.chg   = ec;
        e.score = es;
        e.cyc   = cyc + 1 + nn;
        case (inst)
            0:       begin q_a.push_back(e); start_a = 1'b1; end
            1:       begin q_b.push_back(e); start_b = 1'b1; end
            default: begin q_c.push_back(e); start_c = 1'b1; end
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        board_in  = ~b;
        direction = ~d;
        case (inst)
            0:       check("a_busy_run", 64'(busy_a), 64'd1);
            1:       check("b_busy_run", 64'(busy_b), 64'd1);
            default: check("c_busy_run", 64'(busy_c), 64'd1);
        endcase
        repeat (nn + 2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required end before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        start_c   = 1'b0;
        direction = 2'd0;
        board_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy_a), 64'd0);
        check("rst_done",  64'(done_a), 64'd0);
        check("rst_board", bo_a, 64'd0);
        check("rst_chg",   64'(chg_a), 64'd0);
        check("rst_score", 64'(sc_a), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_move(0, 2'd0, 64'h0000_0000_0000_2211, 64'h0000_0000_0000_0032, 1'b1, 16'd12);
        do_move(0, 2'd1, 64'h0000_0000_0000_0111, 64'h0000_0000_0000_2100, 1'b1, 16'd4);
        do_move(0, 2'd2, 64'h0002_0000_0002_0000, 64'h0000_0000_0000_0003, 1'b1, 16'd8);
        do_move(0, 2'd3, 64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0, 16'd0);
        do_move(0, 2'd0, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 1'b0, 16'd0);
        do_move(0, 2'd0, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_0022, 1'b1, 16'd8);
        do_move(0, 2'd0, 64'h0000_5000_3202_0000, 64'h0000_0005_0033_0000, 1'b1, 16'd8);
        do_move(0, 2'd0, 64'hEE00_0000_0000_00EE, 64'h000F_0000_0000_000F, 1'b1, 16'hFFFF);
        do_move(0, 2'd3, 64'h1000_1000_1000_1000, 64'h2000_2000_0000_0000, 1'b1, 16'd8);
        do_move(1, 2'd0, 64'h0000_0000_0000_0033, 64'h0000_0000_0000_0004, 1'b1, 16'd15);
        do_move(2, 2'd0, 64'h0000_0000_0000_0222, 64'h0000_0000_0000_0023, 1'b1, 16'd8);

        // start held through RUN and DONE with a changing board: exactly one result.
        @(negedge clk);
        direction = 2'd0;
        board_in  = 64'h0000_0000_0000_2211;
        e.board = 64'h0000_0000_0000_0032;
        e.chg   = 1'b1;
        e.score = 16'd12;
        e.cyc   = cyc + 1 + 4;
        q_a.push_back(e);
        start_a = 1'b1;
        @(negedge clk);
        board_in  = 64'h0000_0000_0000_1111;
        direction = 2'd1;
        repeat (5) @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        check("hold_board", bo_a, 64'h0000_0000_0000_0032);
        check("hold_score", 64'(sc_a), 64'd12);
        check("hold_busy",  64'(busy_a), 64'd0);

        // Reset in the middle of RUN: aborted move must not produce a done.
        @(negedge clk);
        direction = 2'd0;
        board_in  = 64'h0000_0000_0000_1111;
        start_a   = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("mid_busy", 64'(busy_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",  64'(busy_a), 64'd0);
        check("abort_done",  64'(done_a), 64'd0);
        check("abort_board", bo_a, 64'd0);
        check("abort_score", 64'(sc_a), 64'd0);
        check("abort_chg",   64'(chg_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        check("a_pending", 64'(q_a.size()), 64'd0);
        check("b_pending", 64'(q_b.size()), 64'd0);
        check("c_pending", 64'(q_c.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end
endmodule
